// File: rtl/arb_mux_rr.sv
// arb_mux_rr: N-channel round-robin arbitrating multiplexer with one
// registered output stage and valid/ready handshakes on every channel.
module arb_mux_rr #(
   parameter int WIDTH = 64,
   parameter int N = 4,
   localparam int SELW = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_sel
);

   logic [SELW-1:0] ptr;
   logic [SELW-1:0] grant;
   logic [SELW-1:0] hi_grant;
   logic [SELW-1:0] lo_grant;
   logic            hi_found;
   logic            any_valid;
   logic            load_en;
   logic            take;

   assign any_valid = |in_valid;
   assign load_en   = !out_valid || out_ready;
   assign take      = load_en && any_valid;

   // Round-robin search: the lowest requester at or above ptr wins, otherwise
   // the lowest requester overall (the search wrapped past N-1).
   always_comb begin
      hi_grant = '0;
      lo_grant = '0;
      hi_found = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (in_valid[k]) begin
            lo_grant = SELW'(k);
            if (k >= int'(ptr)) begin
               hi_grant = SELW'(k);
               hi_found = 1'b1;
            end
         end
      end
      grant = hi_found ? hi_grant : lo_grant;
   end

   // Only the granted channel sees ready, and only when the register can load.
   always_comb begin
      in_ready = '0;
      if (take) begin
         in_ready[grant] = 1'b1;
      end
   end

   // Output register and pointer: load on a grant, empty on an idle drain,
   // hold everything under backpressure.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         if (any_valid) begin
            out_valid <= 1'b1;
            out_data  <= in_data[int'(grant)*WIDTH +: WIDTH];
            out_sel   <= grant;
            ptr       <= (grant == SELW'(N - 1)) ? '0 : grant + 1'b1;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_arb_mux_rr.sv
// tb_arb_mux_rr: directed vector bench for arb_mux_rr (N=4 and N=3 instances).
module tb_arb_mux_rr;

   logic        clk;
   logic        reset_n;

   logic [63:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_sel;

   logic [23:0] in_data3;
   logic [2:0]  in_valid3;
   logic [2:0]  in_ready3;
   logic [7:0]  out_data3;
   logic        out_valid3;
   logic        out_ready3;
   logic [1:0]  out_sel3;

   int checks;
   int errors;

   typedef struct {
      logic [3:0]  iv;
      logic        ordy;
      logic [15:0] tag;
      logic [3:0]  exp_rdy;
      logic        exp_ov;
      logic [1:0]  exp_sel;
      logic [15:0] exp_data;
   } vec_t;

   vec_t vecs[27];

   arb_mux_rr #(.WIDTH(16), .N(4)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_data  (in_data),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .out_data (out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_sel  (out_sel)
   );

   arb_mux_rr #(.WIDTH(8), .N(3)) dut3 (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_data  (in_data3),
      .in_valid (in_valid3),
      .in_ready (in_ready3),
      .out_data (out_data3),
      .out_valid(out_valid3),
      .out_ready(out_ready3),
      .out_sel  (out_sel3)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] iv, input logic ordy, input logic [15:0] tag);
      in_valid  = iv;
      out_ready = ordy;
      in_data   = {tag + 16'd3, tag + 16'd2, tag + 16'd1, tag};
   endtask

   // Main test sequence.
   initial begin
      checks     = 0;
      errors     = 0;
      reset_n    = 1'b0;
      in_valid   = '0;
      in_data    = '0;
      out_ready  = 1'b0;
      in_valid3  = '0;
      in_data3   = '0;
      out_ready3 = 1'b0;

      // fair rotation, all valid
      vecs[0]  = '{4'b1111, 1'b1, 16'h0100, 4'b0001, 1'b1, 2'd0, 16'h0100};
      vecs[1]  = '{4'b1111, 1'b1, 16'h0110, 4'b0010, 1'b1, 2'd1, 16'h0111};
      vecs[2]  = '{4'b1111, 1'b1, 16'h0120, 4'b0100, 1'b1, 2'd2, 16'h0122};
      vecs[3]  = '{4'b1111, 1'b1, 16'h0130, 4'b1000, 1'b1, 2'd3, 16'h0133};
      vecs[4]  = '{4'b1111, 1'b1, 16'h0140, 4'b0001, 1'b1, 2'd0, 16'h0140};
      vecs[5]  = '{4'b1111, 1'b1, 16'h0150, 4'b0010, 1'b1, 2'd1, 16'h0151};
      vecs[6]  = '{4'b1111, 1'b1, 16'h0160, 4'b0100, 1'b1, 2'd2, 16'h0162};
      vecs[7]  = '{4'b1111, 1'b1, 16'h0170, 4'b1000, 1'b1, 2'd3, 16'h0173};
      // lone requester on channel 2, data 0xA0..0xA4
      vecs[8]  = '{4'b0100, 1'b1, 16'h009E, 4'b0100, 1'b1, 2'd2, 16'h00A0};
      vecs[9]  = '{4'b0100, 1'b1, 16'h009F, 4'b0100, 1'b1, 2'd2, 16'h00A1};
      vecs[10] = '{4'b0100, 1'b1, 16'h00A0, 4'b0100, 1'b1, 2'd2, 16'h00A2};
      vecs[11] = '{4'b0100, 1'b1, 16'h00A1, 4'b0100, 1'b1, 2'd2, 16'h00A3};
      vecs[12] = '{4'b0100, 1'b1, 16'h00A2, 4'b0100, 1'b1, 2'd2, 16'h00A4};
      // load 0x1234 from ch1, then backpressure, then no-bubble reload from ch2
      vecs[13] = '{4'b0010, 1'b1, 16'h1233, 4'b0010, 1'b1, 2'd1, 16'h1234};
      vecs[14] = '{4'b1111, 1'b0, 16'h2000, 4'b0000, 1'b1, 2'd1, 16'h1234};
      vecs[15] = '{4'b1111, 1'b0, 16'h2100, 4'b0000, 1'b1, 2'd1, 16'h1234};
      vecs[16] = '{4'b1111, 1'b0, 16'h2200, 4'b0000, 1'b1, 2'd1, 16'h1234};
      vecs[17] = '{4'b1111, 1'b1, 16'h3000, 4'b0100, 1'b1, 2'd2, 16'h3002};
      // pointer skip: ptr -> 1, then 1001 grants 3, then 0
      vecs[18] = '{4'b0001, 1'b1, 16'h4000, 4'b0001, 1'b1, 2'd0, 16'h4000};
      vecs[19] = '{4'b1001, 1'b1, 16'h4100, 4'b1000, 1'b1, 2'd3, 16'h4103};
      vecs[20] = '{4'b1001, 1'b1, 16'h4200, 4'b0001, 1'b1, 2'd0, 16'h4200};
      // idle drain keeps ptr at 1, so next all-valid grant is 1
      vecs[21] = '{4'b0000, 1'b1, 16'h4250, 4'b0000, 1'b0, 2'd0, 16'h4200};
      vecs[22] = '{4'b1111, 1'b1, 16'h4300, 4'b0010, 1'b1, 2'd1, 16'h4301};
      // hold when full and stalled, drain, then load into an empty register while stalled
      vecs[23] = '{4'b0000, 1'b0, 16'h4350, 4'b0000, 1'b1, 2'd1, 16'h4301};
      vecs[24] = '{4'b0100, 1'b0, 16'h4400, 4'b0000, 1'b1, 2'd1, 16'h4301};
      vecs[25] = '{4'b0000, 1'b1, 16'h4450, 4'b0000, 1'b0, 2'd1, 16'h4301};
      vecs[26] = '{4'b0100, 1'b0, 16'h4500, 4'b0100, 1'b1, 2'd2, 16'h4502};

      // reset state
      #12;
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset out_data", 32'(out_data), 32'd0);
      checkOutput("reset out_sel", 32'(out_sel), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 27; i++) begin
         applyStimulus(vecs[i].iv, vecs[i].ordy, vecs[i].tag);
         #1;
         checkOutput($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].exp_rdy));
         @(posedge clk);
         #1;
         checkOutput($sformatf("v%0d out_valid", i), 32'(out_valid), 32'(vecs[i].exp_ov));
         checkOutput($sformatf("v%0d out_sel", i), 32'(out_sel), 32'(vecs[i].exp_sel));
         checkOutput($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].exp_data));
         @(negedge clk);
      end

      // asynchronous reset mid-stream while a beat is held under backpressure
      applyStimulus(4'b1111, 1'b0, 16'h5000);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async rst out_valid", 32'(out_valid), 32'd0);
      checkOutput("async rst out_data", 32'(out_data), 32'd0);
      checkOutput("async rst out_sel", 32'(out_sel), 32'd0);
      checkOutput("async rst in_ready", 32'(in_ready), 32'b0001);
      @(negedge clk);
      reset_n = 1'b1;
      applyStimulus(4'b1111, 1'b1, 16'h5100);
      @(posedge clk);
      #1;
      checkOutput("post rst sel0", 32'(out_sel), 32'd0);
      checkOutput("post rst data0", 32'(out_data), 32'h5100);
      checkOutput("post rst valid0", 32'(out_valid), 32'd1);
      @(negedge clk);
      applyStimulus(4'b1111, 1'b1, 16'h5200);
      @(posedge clk);
      #1;
      checkOutput("post rst sel1", 32'(out_sel), 32'd1);
      checkOutput("post rst data1", 32'(out_data), 32'h5201);
      @(negedge clk);
      applyStimulus(4'b0000, 1'b1, 16'h0000);

      // N=3 rotation: 0,1,2,0,1 and never index 3
      in_valid3  = 3'b111;
      out_ready3 = 1'b1;
      in_data3   = {8'h32, 8'h31, 8'h30};
      for (int i = 0; i < 5; i++) begin
         #1;
         checkOutput($sformatf("n3 c%0d in_ready", i), 32'(in_ready3), 32'(3'b001 << (i % 3)));
         @(posedge clk);
         #1;
         checkOutput($sformatf("n3 c%0d out_sel", i), 32'(out_sel3), 32'(i % 3));
         checkOutput($sformatf("n3 c%0d out_data", i), 32'(out_data3), 32'(8'h30 + 8'(i % 3)));
         checkOutput($sformatf("n3 c%0d sel!=3", i), 32'(out_sel3 == 2'd3), 32'd0);
         @(negedge clk);
      end
      in_valid3 = '0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
